// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sort_pkg
// Brief    : Shared sort-engine geometry, filler word and job FSM encoding.
// Revision : 1.0
// ============================================================================
package sort_pkg;

    localparam int unsigned SORT_N   = 16;
    localparam int unsigned SORT_W   = 32;
    // Largest finite positive single-precision value: padding sorts to the tail.
    localparam logic [31:0] SORT_PAD = 32'h7F7F_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PAD   = 3'd2,
        ST_SORT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sort_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-request round-robin arbiter; grant is combinational, the
//            last-served pointer advances only when a job is retired.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] served,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (upd && (served != 2'b00)) begin
            last_d = served[1];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            // Pointing at requester 1 makes requester 0 win the first tie.
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sort_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sort_job_arbiter
// Brief    : Shares one N-element sort engine between two requesters, pads
//            short jobs and forwards only the caller's sorted results.
// Revision : 1.0
// ============================================================================
module sort_job_arbiter
    import sort_pkg::*;
#(
    parameter int unsigned  N   = SORT_N,
    parameter int unsigned  W   = SORT_W,
    parameter logic [W-1:0] PAD = W'(SORT_PAD)
) (
    input  logic         clk,
    input  logic         res,
    input  logic [1:0]   req,
    input  logic [4:0]   len0,
    input  logic [4:0]   len1,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    input  logic [1:0]   din_vld,
    output logic [1:0]   din_rdy,
    output logic [1:0]   gnt,
    output logic [W-1:0] dout,
    output logic [1:0]   dout_vld,
    output logic         dout_last,
    output logic [1:0]   job_done,
    output logic         eng_start,
    output logic [W-1:0] eng_din,
    output logic         eng_din_vld,
    input  logic [W-1:0] eng_dout,
    input  logic         eng_dout_vld,
    input  logic         eng_done
);

    localparam int unsigned   CW  = $clog2(N) + 1;
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [CW-1:0] ONE = CW'(1);

    sort_state_e   state_q,       state_d;
    logic [1:0]    gnt_q,         gnt_d;
    logic [CW-1:0] jl_q,          jl_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic [CW-1:0] rcnt_q,        rcnt_d;
    logic          eng_start_q,   eng_start_d;
    logic [W-1:0]  eng_din_q,     eng_din_d;
    logic          eng_din_vld_q, eng_din_vld_d;
    logic [W-1:0]  dout_q,        dout_d;
    logic [1:0]    dout_vld_q,    dout_vld_d;
    logic          dout_last_q,   dout_last_d;

    logic [1:0]    arb_gnt;
    logic [4:0]    len_g;
    logic [CW-1:0] len_sat;
    logic [W-1:0]  din_g;
    logic          xfer;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .res    (res),
        .req    (req),
        .upd    (state_q == ST_DONE),
        .served (gnt_q),
        .gnt    (arb_gnt)
    );

    assign len_g   = arb_gnt[1] ? len1 : len0;
    assign len_sat = (32'(len_g) > N) ? N_C : CW'(len_g);
    assign din_g   = gnt_q[1] ? din1 : din0;

    // Ready depends only on state so the handshake never loops through inputs.
    assign din_rdy  = (state_q == ST_LOAD) ? gnt_q : 2'b00;
    assign xfer     = (state_q == ST_LOAD) && ((din_vld & gnt_q) != 2'b00);
    assign job_done = (state_q == ST_DONE) ? gnt_q : 2'b00;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        jl_d          = jl_q;
        cnt_d         = cnt_q;
        rcnt_d        = rcnt_q;
        eng_start_d   = 1'b0;
        eng_din_d     = eng_din_q;
        eng_din_vld_d = 1'b0;
        dout_d        = dout_q;
        dout_vld_d    = 2'b00;
        dout_last_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d  = arb_gnt;
                    jl_d   = len_sat;
                    cnt_d  = '0;
                    rcnt_d = '0;
                    if (len_sat == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_LOAD;
                        eng_start_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (xfer) begin
                    eng_din_d     = din_g;
                    eng_din_vld_d = 1'b1;
                    cnt_d         = cnt_q + ONE;
                    if ((cnt_q + ONE) == jl_q) begin
                        state_d = (jl_q < N_C) ? ST_PAD : ST_SORT;
                    end
                end
            end

            ST_PAD: begin
                eng_din_d     = PAD;
                eng_din_vld_d = 1'b1;
                cnt_d         = cnt_q + ONE;
                if ((cnt_q + ONE) == N_C) begin
                    state_d = ST_SORT;
                end
            end

            ST_SORT, ST_DRAIN: begin
                // Engine results beyond jl are the padding and are dropped.
                if (eng_dout_vld) begin
                    state_d = ST_DRAIN;
                    rcnt_d  = rcnt_q + ONE;
                    if (rcnt_q < jl_q) begin
                        dout_d      = eng_dout;
                        dout_vld_d  = gnt_q;
                        dout_last_d = ((rcnt_q + ONE) == jl_q);
                    end
                end
                if (eng_done || (eng_dout_vld && ((rcnt_q + ONE) == N_C))) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 2'b00;
            jl_q          <= '0;
            cnt_q         <= '0;
            rcnt_q        <= '0;
            eng_start_q   <= 1'b0;
            eng_din_q     <= '0;
            eng_din_vld_q <= 1'b0;
            dout_q        <= '0;
            dout_vld_q    <= 2'b00;
            dout_last_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            jl_q          <= jl_d;
            cnt_q         <= cnt_d;
            rcnt_q        <= rcnt_d;
            eng_start_q   <= eng_start_d;
            eng_din_q     <= eng_din_d;
            eng_din_vld_q <= eng_din_vld_d;
            dout_q        <= dout_d;
            dout_vld_q    <= dout_vld_d;
            dout_last_q   <= dout_last_d;
        end
    end

    assign gnt         = gnt_q;
    assign eng_start   = eng_start_q;
    assign eng_din     = eng_din_q;
    assign eng_din_vld = eng_din_vld_q;
    assign dout        = dout_q;
    assign dout_vld    = dout_vld_q;
    assign dout_last   = dout_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_job_arbiter
// Brief    : Directed and randomized jobs against a behavioural engine and a
//            sorted-result reference model.
// Revision : 1.0
// ============================================================================
module tb_sort_job_arbiter;
    import sort_pkg::*;

    localparam int N = SORT_N;
    localparam int W = SORT_W;

    logic         clk = 1'b0;
    logic         res;
    logic [1:0]   req;
    logic [4:0]   len0, len1;
    logic [W-1:0] din0, din1;
    logic [1:0]   din_vld;
    logic [1:0]   din_rdy, gnt, dout_vld, job_done;
    logic [W-1:0] dout, eng_din, eng_dout;
    logic         dout_last, eng_start, eng_din_vld, eng_dout_vld, eng_done;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sq[$];
    logic [W-1:0] oq[$];
    int           emitted = 0;
    int           eng_pos;
    int           cut = N;
    bit           spur = 1'b0;

    logic [W-1:0] got_d[$];
    logic [1:0]   got_t[$];
    logic         got_l[$];
    int           n_start = 0;
    int           n_ein = 0;

    bit           use_fixed = 1'b0;
    logic [W-1:0] fixed_w[5];

    sort_job_arbiter dut (
        .clk          (clk),
        .res          (res),
        .req          (req),
        .len0         (len0),
        .len1         (len1),
        .din0         (din0),
        .din1         (din1),
        .din_vld      (din_vld),
        .din_rdy      (din_rdy),
        .gnt          (gnt),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .dout_last    (dout_last),
        .job_done     (job_done),
        .eng_start    (eng_start),
        .eng_din      (eng_din),
        .eng_din_vld  (eng_din_vld),
        .eng_dout     (eng_dout),
        .eng_dout_vld (eng_dout_vld),
        .eng_done     (eng_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctrl"}, {gnt, din_rdy, dout_vld, dout_last, job_done, eng_start, eng_din_vld}, '0);
        chk({tag, "_data"}, {eng_din, dout}, '0);
    endtask

    // Engine: collects N loaded words, then streams them back ascending.
    initial begin
        eng_dout     = '0;
        eng_dout_vld = 1'b0;
        eng_done     = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            eng_dout_vld = 1'b0;
            eng_done     = 1'b0;
            if (res) begin
                sq.delete();
                oq.delete();
                emitted = 0;
            end else if (spur) begin
                eng_dout     = $urandom;
                eng_dout_vld = 1'b1;
            end else begin
                if (oq.size() > 0) begin
                    eng_dout     = oq.pop_front();
                    eng_dout_vld = 1'b1;
                    emitted++;
                    if (oq.size() == 0 || emitted >= cut) begin
                        eng_done = 1'b1;
                        oq.delete();
                    end
                end
                if (eng_din_vld) begin
                    eng_pos = 0;
                    while (eng_pos < sq.size() && sq[eng_pos] <= eng_din) eng_pos++;
                    sq.insert(eng_pos, eng_din);
                    if (sq.size() == N) begin
                        oq = sq;
                        sq.delete();
                        emitted = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (res !== 1'b1) begin
            if (dout_vld != 2'b00) begin
                got_d.push_back(dout);
                got_t.push_back(dout_vld);
                got_l.push_back(dout_last);
            end
            if (eng_start)   n_start++;
            if (eng_din_vld) n_ein++;
            if ((gnt | din_rdy | dout_vld | job_done) != 2'b00)
                chk("exclusive", {gnt == 2'b11, (din_rdy | dout_vld | job_done) & ~gnt}, 3'b000);
        end
    end

    task automatic run_job(input int r, input int len, input int vld_pct, input int cut_n, input bit do_res);
        logic [W-1:0] words[$];
        logic [W-1:0] acc[$];
        logic [W-1:0] tmp[$];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] prev_w;
        logic [1:0]   exp_g, jd;
        int           jl, idx, cyc, m, exp_n, n_cmp;
        bit           prev_hs, hs, v, gnt_seen, done_seen;

        jl = (len > N) ? N : len;
        for (int i = 0; i < len; i++)
            words.push_back(use_fixed ? fixed_w[i] : W'($urandom_range(32'h7F00_0000, 0)));
        exp_g = (r == 0) ? 2'b01 : 2'b10;
        got_d.delete(); got_t.delete(); got_l.delete();
        n_start = 0; n_ein = 0; cut = cut_n;
        prev_hs = 1'b0; prev_w = '0; idx = 0; cyc = 0;
        gnt_seen = 1'b0; done_seen = 1'b0; jd = 2'b00;

        @(negedge clk);
        req = exp_g;
        if (r == 0) len0 = 5'(len); else len1 = 5'(len);
        din_vld = 2'b00;

        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (prev_hs) begin
                chk("load_echo_vld", eng_din_vld, 1'b1);
                chk("load_echo_data", eng_din, prev_w);
            end else if (acc.size() < jl) begin
                chk("load_gap_vld", eng_din_vld, 1'b0);
            end
            if (!gnt_seen && gnt != 2'b00) begin
                gnt_seen = 1'b1;
                chk("grant", gnt, exp_g);
                req = 2'b00;
            end
            if (job_done != 2'b00) begin
                done_seen = 1'b1;
                jd = job_done;
            end
            if (do_res && got_d.size() >= 2 && !done_seen) begin
                res = 1'b1; req = 2'b00; din_vld = 2'b00;
                @(negedge clk);
                check_idle("mid_reset");
                res = 1'b0; cut = N;
                @(negedge clk);
                check_idle("post_reset");
                return;
            end
            v = (idx < len) && ($urandom_range(99, 0) < vld_pct);
            if (r == 0) begin
                din0    = (idx < len) ? words[idx] : W'($urandom);
                din1    = $urandom;
                din_vld = {1'($urandom_range(1, 0)), v};
            end else begin
                din1    = (idx < len) ? words[idx] : W'($urandom);
                din0    = $urandom;
                din_vld = {v, 1'($urandom_range(1, 0))};
            end
            hs = din_vld[r] & din_rdy[r];
            if (hs) begin
                acc.push_back(words[idx]);
                prev_w = words[idx];
                idx++;
            end
            prev_hs = hs;
        end
        din_vld = 2'b00;

        chk("job_done_seen", done_seen, 1'b1);
        chk("job_done_tag", jd, exp_g);
        if (len == 0) chk("skip_latency_ok", cyc <= 3, 1'b1);
        repeat (2) @(negedge clk);
        chk("gnt_cleared", gnt, 2'b00);
        chk("accepted", acc.size(), jl);

        tmp = acc;
        while (tmp.size() > 0) begin
            m = 0;
            for (int i = 1; i < tmp.size(); i++) if (tmp[i] < tmp[m]) m = i;
            exp_q.push_back(tmp[m]);
            tmp.delete(m);
        end
        exp_n = (cut_n < jl) ? cut_n : jl;
        chk("n_out", got_d.size(), exp_n);
        n_cmp = (got_d.size() < exp_n) ? got_d.size() : exp_n;
        for (int k = 0; k < n_cmp; k++) begin
            chk("out_data", got_d[k], exp_q[k]);
            chk("out_tag", got_t[k], exp_g);
            chk("out_last", got_l[k], k == jl - 1);
        end
        chk("eng_start_cnt", n_start, (jl > 0) ? 1 : 0);
        chk("eng_in_cnt", n_ein, (jl > 0) ? N : 0);
        cut = N;
    endtask

    initial begin
        logic [1:0] tags[$];
        logic [1:0] t0, t1;

        res = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        din0 = '0; din1 = '0; din_vld = 2'b00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        res = 1'b0;

        // Both requesters held: requester 0 first, then 1.
        req = 2'b11; len0 = 5'd3; len1 = 5'd3; din_vld = 2'b11;
        for (int c = 0; c < 300 && tags.size() < 2; c++) begin
            @(negedge clk);
            din0 = W'($urandom_range(32'h7F00_0000, 0));
            din1 = W'($urandom_range(32'h7F00_0000, 0));
            if (job_done != 2'b00) begin
                tags.push_back(job_done);
                if (tags.size() == 2) req = 2'b00;
            end
        end
        din_vld = 2'b00;
        chk("alt_jobs", tags.size(), 2);
        t0 = (tags.size() > 0) ? tags[0] : 2'b00;
        t1 = (tags.size() > 1) ? tags[1] : 2'b00;
        chk("alt_first", t0, 2'b01);
        chk("alt_second", t1, 2'b10);
        repeat (3) @(negedge clk);

        spur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("spurious_eng_dout", {dout_vld, dout_last, gnt}, '0);
        spur = 1'b0;
        repeat (2) @(negedge clk);

        fixed_w[0] = 32'd9; fixed_w[1] = 32'd3; fixed_w[2] = 32'd7;
        fixed_w[3] = 32'd1; fixed_w[4] = 32'd5;
        use_fixed = 1'b1;
        run_job(0, 5, 100, N, 1'b0);
        use_fixed = 1'b0;

        run_job(1, 0, 100, N, 1'b0);
        run_job(0, 20, 100, N, 1'b0);
        run_job(1, 7, 50, N, 1'b0);
        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(1, 0)), int'($urandom_range(20, 0)),
                    int'($urandom_range(100, 30)), N, 1'b0);
        run_job(0, 10, 80, 6, 1'b0);
        run_job(1, 16, 100, N, 1'b1);
        run_job(0, 2, 100, N, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
